// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: operation codes and controller states.
// No ports; imported by the interface, the multiplier and the top level.
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Handshake bundle between the register-file read stage (master) and the ALU
// (slave).
//   in_valid/in_ready   : operand request handshake
//   val_A/val_B/ALU_op  : operands and operation, sampled on accept
//   out_valid/out_ready : result handshake towards writeback
//   ALU_out, Z/N/C/V    : registered result and flags
interface seq_alu_if #(
  parameter int WIDTH = 16
);
  import seq_alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] val_A;
  logic [WIDTH-1:0] val_B;
  alu_op_e          ALU_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALU_out;
  logic             Z;
  logic             N;
  logic             C;
  logic             V;

  modport master (
    output in_valid, val_A, val_B, ALU_op, out_ready,
    input  in_ready, out_valid, ALU_out, Z, N, C, V
  );

  modport slave (
    input  in_valid, val_A, val_B, ALU_op, out_ready,
    output in_ready, out_valid, ALU_out, Z, N, C, V
  );

endinterface

// File: rtl/seq_alu_mul_iter.sv
// Iterative unsigned shift-add multiplier.
//   clk, rst    : clock, synchronous active-high reset (control only)
//   i_start     : latch i_a/i_b and begin; ignored bits of state are cleared
//   i_a, i_b    : WIDTH-bit unsigned operands
//   o_busy      : a multiplication is in progress
//   o_done      : the final step is happening this cycle; o_product is the
//                 complete product and may be captured on this edge
//   o_product   : 2*WIDTH-bit running sum including the current step
module seq_alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);
  localparam int SHW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_a;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic [SHW-1:0]     r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_last;

  // Exposing the sum-with-current-step lets the caller capture the product on
  // the WIDTH-th step edge instead of one cycle later.
  assign w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);
  assign w_last    = r_busy && (r_cnt == SHW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
    end else if (r_busy) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_busy <= 1'b0;
    end
  end

  // Operand/accumulator registers carry no reset: they are reloaded on start.
  always_ff @(posedge clk) begin
    if (i_start) begin
      r_a   <= {{WIDTH{1'b0}}, i_a};
      r_b   <= i_b;
      r_acc <= '0;
    end else if (r_busy) begin
      r_acc <= w_acc_nxt;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = w_last;
  assign o_product = w_acc_nxt;

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU. Single-cycle ops register their result on the
// accept edge; MUL runs WIDTH shift-add steps in the sub-multiplier.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : seq_alu_if.slave (operand request, result/flags handshake)
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus
);
  import seq_alu_pkg::*;

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  alu_state_e         r_state;
  alu_state_e         w_state_nxt;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_is_mul;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH:0]     w_wide;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0]   r_result;
  logic               r_z;
  logic               r_n;
  logic               r_c;
  logic               r_v;

  assign w_is_mul = (bus.ALU_op == OP_MUL);
  assign w_accept = bus.in_valid && w_in_ready;
  assign w_shamt  = bus.val_B[SHW-1:0];

  seq_alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_accept && w_is_mul),
    .i_a       (bus.val_A),
    .i_b       (bus.val_B),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  // ---- FSM state register ----
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---- FSM next state ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) w_state_nxt = w_is_mul ? ST_MUL : ST_DONE;
      end
      ST_MUL: begin
        // Falling out of MUL without a done pulse only happens if the
        // multiplier was disturbed; return to IDLE rather than hang.
        if (w_mul_done)       w_state_nxt = ST_DONE;
        else if (!w_mul_busy) w_state_nxt = ST_IDLE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          if (!bus.in_valid) w_state_nxt = ST_IDLE;
          else               w_state_nxt = w_is_mul ? ST_MUL : ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---- FSM outputs ----
  // Accepting in DONE is only safe when the held result retires the same edge.
  always_comb begin
    w_in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready);
    w_out_valid = (r_state == ST_DONE);
  end

  // ---- single-cycle datapath ----
  always_comb begin
    w_wide = '0;
    w_res  = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    case (bus.ALU_op)
      OP_ADD: begin
        w_wide = {1'b0, bus.val_A} + {1'b0, bus.val_B};
        w_res  = w_wide[WIDTH-1:0];
        w_c    = w_wide[WIDTH];
        w_v    = (bus.val_A[MSB] == bus.val_B[MSB]) && (w_res[MSB] != bus.val_A[MSB]);
      end
      OP_SUB: begin
        // Extended MSB is the borrow; carry is its complement.
        w_wide = {1'b0, bus.val_A} - {1'b0, bus.val_B};
        w_res  = w_wide[WIDTH-1:0];
        w_c    = ~w_wide[WIDTH];
        w_v    = (bus.val_A[MSB] != bus.val_B[MSB]) && (w_res[MSB] != bus.val_A[MSB]);
      end
      OP_AND: w_res = bus.val_A & bus.val_B;
      OP_OR:  w_res = bus.val_A | bus.val_B;
      OP_XOR: w_res = bus.val_A ^ bus.val_B;
      OP_SHL: begin
        // The guard bit above the result catches the last bit shifted out,
        // and stays 0 for a zero shift.
        w_wide = {1'b0, bus.val_A} << w_shamt;
        w_res  = w_wide[WIDTH-1:0];
        w_c    = w_wide[WIDTH];
      end
      OP_SHR: begin
        w_wide = {bus.val_A, 1'b0} >> w_shamt;
        w_res  = w_wide[WIDTH:1];
        w_c    = w_wide[0];
      end
      default: begin
        w_res = '0;
      end
    endcase
  end

  // ---- output/flag registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_result <= w_res;
      r_z      <= (w_res == '0);
      r_n      <= w_res[MSB];
      r_c      <= w_c;
      r_v      <= w_v;
    end else if ((r_state == ST_MUL) && w_mul_done) begin
      r_result <= w_product[WIDTH-1:0];
      r_z      <= (w_product[WIDTH-1:0] == '0);
      r_n      <= w_product[MSB];
      r_c      <= |w_product[2*WIDTH-1:WIDTH];
      r_v      <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.ALU_out   = r_result;
  assign bus.Z         = r_z;
  assign bus.N         = r_n;
  assign bus.C         = r_c;
  assign bus.V         = r_v;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=16) with a result scoreboard and monitor.
module tb_seq_alu;
  import seq_alu_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  zncv;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;
  int   acc_cyc;
  exp_t sb[$];
  int   pop_cyc[$];

  seq_alu_if #(.WIDTH(16)) bus ();

  seq_alu #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a transfer happens on the next rising edge whenever valid and
  // ready are both high at the falling edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got=%0h expected=none", bus.ALU_out);
      end else begin
        e = sb.pop_front();
        chk("result", 32'(bus.ALU_out), 32'(e.res));
        chk("flags_ZNCV", 32'({bus.Z, bus.N, bus.C, bus.V}), 32'(e.zncv));
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 after the accept edge.
  task automatic issue(input alu_op_e op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] r, input logic [3:0] f, input bit hold);
    int n;
    exp_t e;
    n = 0;
    bus.ALU_op   = op;
    bus.val_A    = a;
    bus.val_B    = b;
    bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 60);
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got=no_accept expected=accept op=%0d", op);
      bus.in_valid = 1'b0;
      @(posedge clk); #2;
      return;
    end
    e.res  = r;
    e.zncv = f;
    sb.push_back(e);
    @(posedge clk); #2;
    acc_cyc = cyc;
    if (!hold) begin
      bus.in_valid = 1'b0;
      bus.val_A    = 16'($urandom);
      bus.val_B    = 16'($urandom);
    end
  endtask

  // Latency is counted so that a result registered on the accept edge is 1.
  task automatic wait_valid(input string name, input int exp_lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 40) begin
      chk("in_ready_while_busy", 32'(bus.in_ready), 32'd0);
      n++;
      @(negedge clk);
    end
    chk(name, 32'(cyc - acc_cyc + 1), 32'(exp_lat));
    @(posedge clk); #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    acc_cyc = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.val_A     = '0;
    bus.val_B     = '0;
    bus.ALU_op    = OP_ADD;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_alu_out", 32'(bus.ALU_out), 32'd0);
    chk("rst_flags", 32'({bus.Z, bus.N, bus.C, bus.V}), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #2;

    // Single-cycle ops, each one cycle after accept.
    issue(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1'b0); wait_valid("lat_add", 1);
    issue(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1'b0); wait_valid("lat_add", 1);
    issue(OP_ADD, 16'h8000, 16'h8000, 16'h0000, 4'b1011, 1'b0); wait_valid("lat_add", 1);
    issue(OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 4'b0100, 1'b0); wait_valid("lat_sub", 1);
    issue(OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 1'b0); wait_valid("lat_sub", 1);
    issue(OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1'b0); wait_valid("lat_and", 1);
    issue(OP_OR,  16'hF0F0, 16'h0F0F, 16'hFFFF, 4'b0100, 1'b0); wait_valid("lat_or", 1);
    issue(OP_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000, 1'b0); wait_valid("lat_xor", 1);
    issue(OP_SHL, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 1'b0); wait_valid("lat_shl", 1);
    issue(OP_SHR, 16'h0003, 16'h0001, 16'h0001, 4'b0010, 1'b0); wait_valid("lat_shr", 1);
    issue(OP_SHL, 16'h1234, 16'h0010, 16'h1234, 4'b0000, 1'b0); wait_valid("lat_shl0", 1);
    issue(OP_SHR, 16'hC000, 16'h000F, 16'h0001, 4'b0010, 1'b0); wait_valid("lat_shr15", 1);

    // Multiplies: WIDTH steps, operands scrambled right after accept.
    issue(OP_MUL, 16'h0100, 16'h0100, 16'h0000, 4'b1010, 1'b0); wait_valid("lat_mul", 17);
    issue(OP_MUL, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 1'b0); wait_valid("lat_mul", 17);
    issue(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010, 1'b0); wait_valid("lat_mul", 17);

    // ADD retiring while a MUL is accepted on the same edge.
    issue(OP_ADD, 16'h0002, 16'h0003, 16'h0005, 4'b0000, 1'b1);
    issue(OP_MUL, 16'h0007, 16'h0009, 16'h003F, 4'b0000, 1'b0); wait_valid("lat_mul_from_done", 17);

    // Reset in the middle of a multiply discards it.
    issue(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("midmul_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midmul_rst_alu_out", 32'(bus.ALU_out), 32'd0);
    chk("midmul_rst_flags", 32'({bus.Z, bus.N, bus.C, bus.V}), 32'd0);
    for (int i = 0; i < 20; i++) begin
      chk("midmul_no_stale", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #2;

    // Back-pressure: result held, no new accept.
    bus.out_ready = 1'b0;
    issue(OP_ADD, 16'h1111, 16'h2222, 16'h3333, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_alu_out", 32'(bus.ALU_out), 32'h3333);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #2;
    pop_cyc.delete();
    bus.out_ready = 1'b1;
    issue(OP_ADD, 16'h0001, 16'h0002, 16'h0003, 4'b0000, 1'b1);
    issue(OP_ADD, 16'h0010, 16'h0020, 16'h0030, 4'b0000, 1'b1);
    issue(OP_ADD, 16'h1000, 16'h2000, 16'h3000, 4'b0000, 1'b1);
    issue(OP_ADD, 16'h4000, 16'h4000, 16'h8000, 4'b0101, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    chk("stream_count", 32'(pop_cyc.size()), 32'd5);
    for (int i = 1; i < pop_cyc.size(); i++)
      chk("stream_consecutive", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
    chk("idle_after_stream", 32'(bus.out_valid), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
